// File: rtl/if_id_queue_if.sv
// ============================================================================
// Module      : if_id_queue_if
// Description : Fetch/decode handshake bundle for the IF->ID instruction queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface if_id_queue_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              if_req_valid;
  logic              if_ready;
  logic [ADDR_W-1:0] if_pc;
  logic [INST_W-1:0] if_inst;
  logic              if_miss;
  logic              if_tlb_valid;
  logic [ADDR_W-1:0] if_inst_addr_v;
  logic              flush;
  logic              id_ready;
  logic              id_valid;
  logic [ADDR_W-1:0] id_pc;
  logic [INST_W-1:0] id_inst;
  logic              id_excp_refill;
  logic              id_excp_invalid;
  logic [ADDR_W-1:0] id_inst_addr_v;
  logic [CNT_W-1:0]  count;

  // Environment side: fetch drives entries, decode drives id_ready.
  modport master (
    output if_req_valid, if_pc, if_inst, if_miss, if_tlb_valid, if_inst_addr_v,
    output flush, id_ready,
    input  if_ready, id_valid, id_pc, id_inst, id_excp_refill, id_excp_invalid,
    input  id_inst_addr_v, count
  );

  modport slave (
    input  if_req_valid, if_pc, if_inst, if_miss, if_tlb_valid, if_inst_addr_v,
    input  flush, id_ready,
    output if_ready, id_valid, id_pc, id_inst, id_excp_refill, id_excp_invalid,
    output id_inst_addr_v, count
  );
endinterface

`default_nettype wire

// File: rtl/if_id_queue.sv
// ============================================================================
// Module      : if_id_queue
// Description : DEPTH-entry in-order IF->ID FIFO with valid/ready on both
//               sides and whole-queue flush. Optional same-cycle bypass of an
//               empty queue is enabled by defining IF_ID_QUEUE_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_queue #(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'hBFC00000
) (
  input  logic         clk,
  input  logic         rst,
  if_id_queue_if.slave bus
);
  localparam int                 c_cnt_w = $clog2(DEPTH + 1);
  localparam int                 c_ptr_w = $clog2(DEPTH);
  localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(DEPTH);
  localparam logic [c_ptr_w-1:0] c_last  = c_ptr_w'(DEPTH - 1);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] addr_v;
    logic              refill;
    logic              invalid;
  } entry_t;

  entry_t             r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_head;
  logic [c_ptr_w-1:0] r_tail;
  logic [c_cnt_w-1:0] r_count;

  entry_t w_in;
  entry_t w_head;
  logic   w_empty;
  logic   w_ready;
  logic   w_byp;
  logic   w_valid;
  logic   w_push;
  logic   w_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [c_ptr_w-1:0] f_next(input logic [c_ptr_w-1:0] p);
    return (p == c_last) ? '0 : p + c_ptr_w'(1);
  endfunction

  assign w_in = '{pc:      bus.if_pc,
                  inst:    bus.if_inst,
                  addr_v:  bus.if_inst_addr_v,
                  refill:  bus.if_miss,
                  invalid: ~bus.if_tlb_valid};

  assign w_empty = (r_count == '0);
  assign w_ready = (r_count < c_full);

`ifdef IF_ID_QUEUE_BYPASS_EN
  assign w_byp = w_empty && bus.if_req_valid && !bus.flush;
`else
  assign w_byp = 1'b0;
`endif

  assign w_valid = !w_empty || w_byp;
  assign w_head  = w_byp ? w_in : r_mem[r_head];
  assign w_pop   = !w_empty && bus.id_ready;
  // A bypassed entry that decode takes immediately is never written.
  assign w_push  = bus.if_req_valid && w_ready && !(w_byp && bus.id_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (bus.flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= f_next(r_tail);
      if (w_pop)  r_head <= f_next(r_head);
      if (w_push && !w_pop)
        r_count <= r_count + c_cnt_w'(1);
      else if (!w_push && w_pop)
        r_count <= r_count - c_cnt_w'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !bus.flush) r_mem[r_tail] <= w_in;
  end

  assign bus.if_ready        = w_ready;
  assign bus.id_valid        = w_valid;
  assign bus.id_pc           = w_valid ? w_head.pc      : RESET_PC;
  assign bus.id_inst         = w_valid ? w_head.inst    : '0;
  assign bus.id_inst_addr_v  = w_valid ? w_head.addr_v  : '0;
  assign bus.id_excp_refill  = w_valid && w_head.refill;
  assign bus.id_excp_invalid = w_valid && w_head.invalid;
  assign bus.count           = r_count;
endmodule

`default_nettype wire

// File: tb/tb_if_id_queue.sv
// ============================================================================
// Module      : tb_if_id_queue
// Description : Drives a DEPTH=4 and a DEPTH=3 queue with identical stimulus
//               and compares both against queue-based reference models.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_if_id_queue;
  localparam logic [31:0] c_reset_pc = 32'hBFC00000;
`ifdef IF_ID_QUEUE_BYPASS_EN
  localparam bit c_byp = 1'b1;
`else
  localparam bit c_byp = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] av;
    logic        refill;
    logic        invalid;
  } entry_t;

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic        req   = 1'b0;
  logic        miss  = 1'b0;
  logic        tlbv  = 1'b1;
  logic        flush = 1'b0;
  logic        idr   = 1'b0;
  logic [31:0] pc    = '0;
  logic [31:0] inst  = '0;
  logic [31:0] av    = '0;

  int n_checks = 0;
  int n_pass   = 0;

  entry_t mq [2][$];
  int     dep [2] = '{4, 3};

  always #5 clk = ~clk;

  if_id_queue_if #(.DEPTH(4), .ADDR_W(32), .INST_W(32)) bus4 ();
  if_id_queue_if #(.DEPTH(3), .ADDR_W(32), .INST_W(32)) bus3 ();

  assign bus4.if_req_valid   = req;   assign bus3.if_req_valid   = req;
  assign bus4.if_pc          = pc;    assign bus3.if_pc          = pc;
  assign bus4.if_inst        = inst;  assign bus3.if_inst        = inst;
  assign bus4.if_miss        = miss;  assign bus3.if_miss        = miss;
  assign bus4.if_tlb_valid   = tlbv;  assign bus3.if_tlb_valid   = tlbv;
  assign bus4.if_inst_addr_v = av;    assign bus3.if_inst_addr_v = av;
  assign bus4.flush          = flush; assign bus3.flush          = flush;
  assign bus4.id_ready       = idr;   assign bus3.id_ready       = idr;

  if_id_queue #(.DEPTH(4), .ADDR_W(32), .INST_W(32), .RESET_PC(c_reset_pc))
    dut4 (.clk(clk), .rst(rst), .bus(bus4));
  if_id_queue #(.DEPTH(3), .ADDR_W(32), .INST_W(32), .RESET_PC(c_reset_pc))
    dut3 (.clk(clk), .rst(rst), .bus(bus3));

  logic        o_valid [2];
  logic        o_ready [2];
  logic        o_ref   [2];
  logic        o_inv   [2];
  logic [31:0] o_pc    [2];
  logic [31:0] o_inst  [2];
  logic [31:0] o_av    [2];
  logic [31:0] o_count [2];

  assign o_valid[0] = bus4.id_valid;        assign o_valid[1] = bus3.id_valid;
  assign o_ready[0] = bus4.if_ready;        assign o_ready[1] = bus3.if_ready;
  assign o_ref[0]   = bus4.id_excp_refill;  assign o_ref[1]   = bus3.id_excp_refill;
  assign o_inv[0]   = bus4.id_excp_invalid; assign o_inv[1]   = bus3.id_excp_invalid;
  assign o_pc[0]    = bus4.id_pc;           assign o_pc[1]    = bus3.id_pc;
  assign o_inst[0]  = bus4.id_inst;         assign o_inst[1]  = bus3.id_inst;
  assign o_av[0]    = bus4.id_inst_addr_v;  assign o_av[1]    = bus3.id_inst_addr_v;
  assign o_count[0] = 32'(bus4.count);      assign o_count[1] = 32'(bus3.count);

  // ---------------- reference model ----------------
  function automatic entry_t in_entry();
    return '{pc, inst, av, miss, ~tlbv};
  endfunction

  function automatic logic exp_valid(int k);
    return (mq[k].size() > 0) || (c_byp && req && !flush);
  endfunction

  function automatic entry_t exp_head(int k);
    if (mq[k].size() > 0) return mq[k][0];
    if (c_byp && req && !flush) return in_entry();
    return '{c_reset_pc, 32'h0, 32'h0, 1'b0, 1'b0};
  endfunction

  always @(posedge clk or negedge rst) begin : m_upd
    bit take, do_pop, do_push;
    if (!rst) begin
      mq[0].delete();
      mq[1].delete();
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (flush) begin
          mq[k].delete();
        end else begin
          take    = c_byp && (mq[k].size() == 0) && req && idr;
          do_pop  = (mq[k].size() > 0) && idr;
          do_push = req && (mq[k].size() < dep[k]) && !take;
          if (do_pop)  void'(mq[k].pop_front());
          if (do_push) mq[k].push_back(in_entry());
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    req = 1'b0; idr = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic offer(input logic [31:0] p, input logic m, input logic tv);
    req = 1'b1; pc = p; inst = $urandom; av = $urandom; miss = m; tlbv = tv;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idr = 1'b0;
    offer(32'h80000A00, 1'b1, 1'b0); step();
    offer(32'h80000A04, 1'b0, 1'b1); step();
    req = 1'b0;
    n_checks++;
    if (o_count[0] !== 32'd2) $display("FAIL reset_precount actual=%0d expected=2", o_count[0]);
    else n_pass++;
    #2 rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({o_valid[k], o_pc[k], o_inst[k], o_av[k], o_ref[k], o_inv[k]} !==
          {1'b0, c_reset_pc, 32'h0, 32'h0, 1'b0, 1'b0})
        $display("FAIL reset_idle[%0d] actual v=%b pc=%h inst=%h av=%h f=%b%b expected idle",
                 k, o_valid[k], o_pc[k], o_inst[k], o_av[k], o_ref[k], o_inv[k]);
      else n_pass++;
      n_checks++;
      if (o_count[k] !== 32'd0 || o_ready[k] !== 1'b1)
        $display("FAIL reset_count[%0d] actual count=%0d ready=%b expected count=0 ready=1",
                 k, o_count[k], o_ready[k]);
      else n_pass++;
    end
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic test_fill_full();
    logic [31:0] got [$];
    logic        acc;
    do_flush();
    for (int i = 0; i < 4; i++) begin
      offer(32'h80000000 + 32'(4 * i), 1'b0, 1'b1);
      step();
    end
    offer(32'h80000010, 1'b0, 1'b1);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if (o_count[0] !== 32'd4 || o_ready[0] !== 1'b0)
        $display("FAIL full_hold cyc%0d actual count=%0d ready=%b expected count=4 ready=0",
                 c, o_count[0], o_ready[0]);
      else n_pass++;
      @(posedge clk); #1;
    end
    idr = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (o_valid[0]) got.push_back(o_pc[0]);
      acc = req && o_ready[0];
      @(posedge clk); #1;
      if (acc) req = 1'b0;
    end
    idr = 1'b0;
    n_checks++;
    if (got.size() != 5) $display("FAIL drain_size actual=%0d expected=5", got.size());
    else n_pass++;
    for (int i = 0; i < got.size() && i < 5; i++) begin
      n_checks++;
      if (got[i] !== 32'h80000000 + 32'(4 * i))
        $display("FAIL drain_order[%0d] actual=%h expected=%h", i, got[i], 32'h80000000 + 32'(4 * i));
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back_wrap();
    int pop_idx;
    logic [31:0] base;
    base = 32'h80000100;
    pop_idx = 0;
    do_flush();
    for (int i = 0; i < 2; i++) begin
      offer(base + 32'(4 * i), 1'b0, 1'b1);
      step();
    end
    idr = 1'b1;
    for (int i = 2; i < 12; i++) begin
      offer(base + 32'(4 * i), 1'b0, 1'b1);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (o_count[k] !== 32'd2) $display("FAIL b2b_count[%0d] i=%0d actual=%0d expected=2", k, i, o_count[k]);
        else n_pass++;
      end
      n_checks++;
      if (o_valid[1] !== 1'b1 || o_pc[1] !== base + 32'(4 * pop_idx))
        $display("FAIL b2b_order i=%0d actual v=%b pc=%h expected v=1 pc=%h",
                 i, o_valid[1], o_pc[1], base + 32'(4 * pop_idx));
      else n_pass++;
      pop_idx++;
      @(posedge clk); #1;
    end
    req = 1'b0; idr = 1'b0;
  endtask

  task automatic test_exceptions();
    do_flush();
    offer(32'h00400000, 1'b1, 1'b0); step();
    offer(32'h00400004, 1'b0, 1'b1); step();
    req = 1'b0; idr = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({o_pc[0], o_ref[0], o_inv[0]} !== {32'h00400000, 1'b1, 1'b1})
      $display("FAIL excp_first actual pc=%h ref=%b inv=%b expected pc=00400000 ref=1 inv=1",
               o_pc[0], o_ref[0], o_inv[0]);
    else n_pass++;
    @(posedge clk); #1;
    idr = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({o_pc[0], o_ref[0], o_inv[0]} !== {32'h00400004, 1'b0, 1'b0})
      $display("FAIL excp_second actual pc=%h ref=%b inv=%b expected pc=00400004 ref=0 inv=0",
               o_pc[0], o_ref[0], o_inv[0]);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    do_flush();
    for (int i = 0; i < 3; i++) begin
      offer(32'h80000200 + 32'(4 * i), 1'b0, 1'b1);
      step();
    end
    offer(32'h80001000, 1'b0, 1'b1);
    idr = 1'b1; flush = 1'b1;
    @(negedge clk);
    n_checks++;
    if (o_count[0] !== 32'd3 || o_ready[0] !== 1'b1)
      $display("FAIL flush_same_cycle actual count=%0d ready=%b expected count=3 ready=1",
               o_count[0], o_ready[0]);
    else n_pass++;
    @(posedge clk); #1;
    flush = 1'b0; req = 1'b0; idr = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if ({o_valid[k], o_pc[k], o_count[k]} !== {1'b0, c_reset_pc, 32'd0})
          $display("FAIL flush_after[%0d] cyc%0d actual v=%b pc=%h count=%0d expected v=0 pc=%h count=0",
                   k, c, o_valid[k], o_pc[k], o_count[k], c_reset_pc);
        else n_pass++;
      end
      @(posedge clk); #1;
    end
    idr = 1'b0;
  endtask

  task automatic test_bypass();
    logic        e_v0, e_v1;
    logic [31:0] e_pc0, e_pc1, e_cnt1;
    e_v0   = c_byp;
    e_pc0  = c_byp ? 32'h80002000 : c_reset_pc;
    e_v1   = !c_byp;
    e_pc1  = c_byp ? c_reset_pc : 32'h80002000;
    e_cnt1 = c_byp ? 32'd0 : 32'd1;
    do_flush();
    offer(32'h80002000, 1'b0, 1'b1);
    idr = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({o_valid[0], o_pc[0], o_count[0]} !== {e_v0, e_pc0, 32'd0})
      $display("FAIL bypass_cycle0 actual v=%b pc=%h count=%0d expected v=%b pc=%h count=0",
               o_valid[0], o_pc[0], o_count[0], e_v0, e_pc0);
    else n_pass++;
    @(posedge clk); #1;
    req = 1'b0; idr = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({o_valid[0], o_pc[0], o_count[0]} !== {e_v1, e_pc1, e_cnt1})
      $display("FAIL bypass_cycle1 actual v=%b pc=%h count=%0d expected v=%b pc=%h count=%0d",
               o_valid[0], o_pc[0], o_count[0], e_v1, e_pc1, e_cnt1);
    else n_pass++;
    @(posedge clk); #1;
    do_flush();
  endtask

  task automatic test_random();
    entry_t e;
    for (int c = 0; c < 400; c++) begin
      req   = ($urandom_range(0, 3) != 0);
      idr   = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 31) == 0);
      pc    = {$urandom_range(0, 32'h3FFFFFFF), 2'b00};
      inst  = $urandom;
      av    = $urandom;
      miss  = 1'($urandom_range(0, 1));
      tlbv  = 1'($urandom_range(0, 1));
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        e = exp_head(k);
        n_checks++;
        if (o_valid[k] !== exp_valid(k) || o_ready[k] !== (mq[k].size() < dep[k]) ||
            o_count[k] !== 32'(mq[k].size()))
          $display("FAIL rand_ctrl[%0d] cyc%0d actual v=%b rdy=%b cnt=%0d expected v=%b rdy=%b cnt=%0d",
                   k, c, o_valid[k], o_ready[k], o_count[k], exp_valid(k),
                   (mq[k].size() < dep[k]), mq[k].size());
        else n_pass++;
        n_checks++;
        if ({o_pc[k], o_inst[k], o_av[k], o_ref[k], o_inv[k]} !== e)
          $display("FAIL rand_data[%0d] cyc%0d actual pc=%h inst=%h av=%h f=%b%b expected pc=%h inst=%h av=%h f=%b%b",
                   k, c, o_pc[k], o_inst[k], o_av[k], o_ref[k], o_inv[k],
                   e.pc, e.inst, e.av, e.refill, e.invalid);
        else n_pass++;
      end
      @(posedge clk); #1;
    end
    req = 1'b0; idr = 1'b0; flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    test_reset();
    test_fill_full();
    test_back_to_back_wrap();
    test_exceptions();
    test_flush();
    test_bypass();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised IF→ID instruction buffer.
- Replaces the single-entry IF/ID pipeline register with a DEPTH-entry in-order FIFO using valid/ready handshakes on both sides.
- Each entry carries pc, instruction, virtual fetch address and TLB exception flags.
- Decouples fetch from decode stalls and supports whole-queue flush on redirect or exception.

Parameters:
- DEPTH, 4, number of entries; must be ≥2; need not be a power of two.
- ADDR_W, 32, width of pc and virtual address fields.
- INST_W, 32, instruction width.
- RESET_PC, 32'hBFC00000, pc value presented on id_pc when no entry is valid.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- if_req_valid  in  1  fetch offers an entry this cycle.
- if_ready  out  1  queue can accept an entry.
- if_pc  in  ADDR_W  physical pc of the fetched instruction.
- if_inst  in  INST_W  fetched instruction word.
- if_miss  in  1  instruction TLB refill miss.
- if_tlb_valid  in  1  TLB entry valid bit (0 = invalid exception).
- if_inst_addr_v  in  ADDR_W  virtual fetch address.
- flush  in  1  synchronous discard of all entries.
- id_ready  in  1  decode accepts the head entry.
- id_valid  out  1  head entry valid.
- id_pc  out  ADDR_W  head pc.
- id_inst  out  INST_W  head instruction.
- id_excp_refill  out  1  head TLB refill flag.
- id_excp_invalid  out  1  head TLB invalid flag.
- id_inst_addr_v  out  ADDR_W  head virtual address.
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- State:
  - storage array of DEPTH entries;
  - head and tail pointers, each wrapping from DEPTH-1 to 0;
  - registered count.
- Reset (rst=0, asynchronous): head=tail=0, count=0; outputs idle immediately.
- Idle values: id_valid=0, id_pc=RESET_PC, id_inst=0, both exception flags 0, id_inst_addr_v=0.
  - Storage contents need not be reset.
- Accept: if_ready = (count < DEPTH), derived only from registered state.
  - A push is if_req_valid && if_ready.
  - Store if_pc, if_inst and if_inst_addr_v unchanged.
  - Store refill = if_miss and invalid = ~if_tlb_valid.
- Deliver: push = if_req_valid && if_ready; pop = id_valid && id_ready.
  - When count>0: id_valid=1 and id_* reflect the entry at head, read combinationally from storage.
  - When count=0: id_* show the idle values.
- Latency: an entry pushed in cycle N appears on id_* in cycle N+1 at the earliest.
- Order: strict FIFO. Fields of an entry are never mixed with fields of another entry.
- Simultaneous push and pop with 0<count<DEPTH: count unchanged; both pointers advance.
- Full (count=DEPTH): if_ready=0 even if a pop happens in the same cycle; the offered entry is not taken and fetch holds it.
- Empty with if_req_valid=1 and id_ready=1: push only; id_valid=0 that cycle.
- Flush=1:
  - next cycle head=tail=0 and count=0;
  - any push or pop in the same cycle is discarded (flush wins);
  - if_ready stays as computed from current count;
  - id_* show idle values from the cycle after flush.
- Pointer wrap: with DEPTH=3, the tail sequence is 0,1,2,0,…; correctness is independent of power-of-two.
- Reset asserted mid-operation: all entries lost immediately; the first push after rst deasserts lands at index 0.

Optional Feature:
- Macro IF_ID_QUEUE_BYPASS_EN.
- Defined:
  - when count=0 and if_req_valid=1, the incoming entry is presented combinationally on id_* with id_valid=1 (exception flags derived as for storage);
  - if id_ready=1 in that cycle, the entry is consumed without being written, and count stays 0;
  - if id_ready=0, the entry is written normally;
  - flush=1 suppresses bypass: id_valid=0 and nothing is written.
- Not defined: behaviour exactly as above; minimum latency is 1 cycle.

Test Plan:
- Reset then idle, with rst=0 pulsed mid-cycle: id_valid=0, id_pc=32'hBFC00000, id_inst=0, count=0, if_ready=1; outputs change without waiting for a clock edge.
- Push pc 0x80000000/04/08/0C with id_ready=0, DEPTH=4: count reaches 4, if_ready=0; a fifth offer (pc 0x80000010) is held. Then id_ready=1: pcs emerge 00,04,08,0C,10 in order with no duplicates.
- Continuous push and pop at count=2 for 10 cycles with DEPTH=3: count stays 2; pointers wrap; every pc appears exactly once and in order.
- Push if_miss=1, if_tlb_valid=0, pc 0x00400000: head shows id_excp_refill=1 and id_excp_invalid=1. The next entry (if_miss=0, if_tlb_valid=1) shows both flags 0.
- Count=3, flush=1 together with push pc 0x80001000 and pop: the next cycle has count=0 and id_valid=0; the pushed entry never appears.
- With IF_ID_QUEUE_BYPASS_EN: empty queue, push pc 0x80002000 with id_ready=1 → id_valid=1 and id_pc=0x80002000 in the same cycle; count stays 0. Without the macro: id_valid=0 that cycle; the entry appears in the next cycle with count=1.
